// File: rtl/led_scroll_engine.sv
// LED scroller: free-running chase pattern, or a message frame stream
// rotated per index, gated by a brightness PWM and advanced on a step tick.
module led_scroll_engine #(
    parameter int                CLK_FREQ   = 48_000_000,
    parameter int                STEP_HZ    = 30,
    parameter int                N_LEDS     = 8,
    parameter int                MSG_DEPTH  = 64,
    parameter int                PWM_BITS   = 4,
    parameter logic [N_LEDS-1:0] CHASE_INIT = 'h5,
    localparam int               AW         = $clog2(MSG_DEPTH),
    localparam int               LW         = $clog2(MSG_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                unlocked,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [LW-1:0]       msg_len,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [N_LEDS-1:0]   wr_data,
    output logic [N_LEDS-1:0]   leds,
    output logic                step,
    output logic                msg_wrap
);

    localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int P        = (1 << PWM_BITS) - 1;

    logic [TW-1:0]       tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LEDS-1:0]   pattern;
    logic [N_LEDS-1:0]   frame;
    logic [AW-1:0]       idx;
    logic                unl_q;
    logic [N_LEDS-1:0]   mem [MSG_DEPTH];

    logic                tick_last;
    logic                pwm_last;
    logic                pwm_on;
    logic                entry;
    logic                len_zero;
    logic                idx_last;
    logic [LW-1:0]       eff_len;
    logic [LW:0]         idx_inc;
    logic [N_LEDS-1:0]   rd_data;

    function automatic logic [N_LEDS-1:0] rotl(input logic [N_LEDS-1:0] x, input int r);
        logic [2*N_LEDS-1:0] d;
        d = {x, x} << r;
        return d[2*N_LEDS-1:N_LEDS];
    endfunction

    assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
    assign pwm_last  = (pwm_cnt == PWM_BITS'(P - 1));
    assign pwm_on    = (pwm_cnt < duty);
    assign entry     = unlocked & ~unl_q;

    // Lengths beyond the memory are clamped so idx never leaves the array.
    assign eff_len  = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    assign len_zero = (eff_len == '0);
    assign idx_inc  = (LW + 1)'(idx) + (LW + 1)'(1);
    // ">=" rather than "==" so a length shrunk below idx still wraps.
    assign idx_last = (idx_inc >= {1'b0, eff_len});
    assign rd_data  = mem[idx];

    assign msg_wrap = step & unlocked & ~len_zero & idx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            step     <= 1'b0;
            pwm_cnt  <= '0;
        end else begin
            tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
            step     <= tick_last;
            pwm_cnt  <= pwm_last ? '0 : pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= CHASE_INIT;
            frame   <= '0;
            idx     <= '0;
            unl_q   <= 1'b0;
            leds    <= '0;
        end else begin
            unl_q <= unlocked;
            if (step)
                pattern <= {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
            // Mode entry restarts the message even if a step lands on the same edge.
            if (entry) begin
                idx   <= '0;
                frame <= '0;
            end else if (step && unlocked) begin
                if (len_zero) begin
                    idx   <= '0;
                    frame <= '0;
                end else begin
                    frame <= rotl(rd_data, int'(idx) % N_LEDS);
                    idx   <= idx_last ? '0 : idx + 1'b1;
                end
            end
            leds <= (unlocked ? frame : pattern) & {N_LEDS{pwm_on}};
        end
    end

    // No reset on the message store; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

endmodule
